// File: rtl/mf8_regfile_p.sv
// Register file with two synchronous read ports, one-cycle-delayed write address,
// write-to-read bypass and X/Y/Z pointer pairs with increment/decrement.
module mf8_regfile_p #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Wr,
  input  logic              Wr_Word,
  input  logic [AW-1:0]     Rd_Addr,
  input  logic [AW-1:0]     Rr_Addr,
  input  logic [DW-1:0]     Data_In,
  input  logic [DW-1:0]     Data_In_Hi,
  input  logic              Ptr_Upd,
  input  logic [1:0]        Ptr_Sel,
  input  logic              Ptr_Dec,
  output logic [DW-1:0]     Rd_Data,
  output logic [DW-1:0]     Rr_Data,
  output logic [2*DW-1:0]   X,
  output logic [2*DW-1:0]   Y,
  output logic [2*DW-1:0]   Z,
  output logic              Ptr_Conflict
);

  localparam int unsigned NREGS = 2**AW;

  // Pointer pairs are even/odd aligned, so a pair is identified by the address without bit 0.
  localparam logic [AW-2:0] X_PAIR = (AW-1)'((NREGS - 6) / 2);
  localparam logic [AW-2:0] Y_PAIR = (AW-1)'((NREGS - 4) / 2);
  localparam logic [AW-2:0] Z_PAIR = (AW-1)'((NREGS - 2) / 2);
  localparam logic [2*DW-1:0] PTR_ONE = (2*DW)'(1);

  logic [DW-1:0]   regs_q [NREGS];
  logic [DW-1:0]   regs_d [NREGS];
  logic [AW-1:0]   wa_q;
  logic [DW-1:0]   rd_data_q;
  logic [DW-1:0]   rr_data_q;
  logic            ptr_conflict_q;
  logic            ptr_conflict_d;

  logic            ptr_req;
  logic [AW-2:0]   ptr_pair;
  logic [2*DW-1:0] ptr_cur;
  logic [2*DW-1:0] ptr_nxt;

  always_comb begin
    regs_d   = regs_q;
    ptr_pair = '0;
    case (Ptr_Sel)
      2'b01:   ptr_pair = X_PAIR;
      2'b10:   ptr_pair = Y_PAIR;
      2'b11:   ptr_pair = Z_PAIR;
      default: ptr_pair = '0;
    endcase

    ptr_req = Ptr_Upd && (Ptr_Sel != 2'b00);
    ptr_cur = {regs_q[{ptr_pair, 1'b1}], regs_q[{ptr_pair, 1'b0}]};
    ptr_nxt = Ptr_Dec ? (ptr_cur - PTR_ONE) : (ptr_cur + PTR_ONE);

    // Any byte or word write landing in the selected pair shares its upper address bits.
    ptr_conflict_d = ptr_req && (Wr || Wr_Word) && (wa_q[AW-1:1] == ptr_pair);

    if (ptr_req && !ptr_conflict_d) begin
      regs_d[{ptr_pair, 1'b0}] = ptr_nxt[DW-1:0];
      regs_d[{ptr_pair, 1'b1}] = ptr_nxt[2*DW-1:DW];
    end

    if (Wr_Word) begin
      regs_d[{wa_q[AW-1:1], 1'b0}] = Data_In;
      regs_d[{wa_q[AW-1:1], 1'b1}] = Data_In_Hi;
    end else if (Wr) begin
      regs_d[wa_q] = Data_In;
    end
  end

  // Read data is taken from the next-state array, which gives the same-cycle bypass.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      regs_q         <= '{default: '0};
      wa_q           <= '0;
      rd_data_q      <= '0;
      rr_data_q      <= '0;
      ptr_conflict_q <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      wa_q           <= Rd_Addr;
      rd_data_q      <= regs_d[Rd_Addr];
      rr_data_q      <= regs_d[Rr_Addr];
      ptr_conflict_q <= ptr_conflict_d;
    end
  end

  assign Rd_Data      = rd_data_q;
  assign Rr_Data      = rr_data_q;
  assign X            = {regs_q[{X_PAIR, 1'b1}], regs_q[{X_PAIR, 1'b0}]};
  assign Y            = {regs_q[{Y_PAIR, 1'b1}], regs_q[{Y_PAIR, 1'b0}]};
  assign Z            = {regs_q[{Z_PAIR, 1'b1}], regs_q[{Z_PAIR, 1'b0}]};
  assign Ptr_Conflict = ptr_conflict_q;

endmodule

// File: tb/tb_mf8_regfile_p.sv
// Scoreboard bench for mf8_regfile_p: directed vectors plus random traffic against a byte-array model.
module tb_mf8_regfile_p;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Wr, Wr_Word;
  logic [AW-1:0] Rd_Addr, Rr_Addr;
  logic [DW-1:0] Data_In, Data_In_Hi;
  logic          Ptr_Upd;
  logic [1:0]    Ptr_Sel;
  logic          Ptr_Dec;
  logic [DW-1:0] Rd_Data, Rr_Data;
  logic [15:0]   X, Y, Z;
  logic          Ptr_Conflict;

  always #5 Clk = ~Clk;

  mf8_regfile_p #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Wr(Wr), .Wr_Word(Wr_Word),
    .Rd_Addr(Rd_Addr), .Rr_Addr(Rr_Addr), .Data_In(Data_In), .Data_In_Hi(Data_In_Hi),
    .Ptr_Upd(Ptr_Upd), .Ptr_Sel(Ptr_Sel), .Ptr_Dec(Ptr_Dec),
    .Rd_Data(Rd_Data), .Rr_Data(Rr_Data), .X(X), .Y(Y), .Z(Z), .Ptr_Conflict(Ptr_Conflict)
  );

  typedef struct packed {
    logic [7:0]  rd;
    logic [7:0]  rr;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        c;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  m [32];
  logic [4:0]  mwa;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic ww, input logic [4:0] rd, input logic [4:0] rr,
                       input logic [7:0] din, input logic [7:0] dhi,
                       input logic pu, input logic [1:0] ps, input logic pd);
    Wr = wr; Wr_Word = ww; Rd_Addr = rd; Rr_Addr = rr;
    Data_In = din; Data_In_Hi = dhi; Ptr_Upd = pu; Ptr_Sel = ps; Ptr_Dec = pd;
  endtask

  task automatic idle(input logic [4:0] rd, input logic [4:0] rr);
    drive(1'b0, 1'b0, rd, rr, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic model_clear();
    foreach (m[i]) m[i] = 8'h00;
    mwa = '0;
    sbq.delete();
  endtask

  // Advance one clock: predict the result of the current inputs, then compare after the edge.
  task automatic cyc();
    logic [7:0]  nm [32];
    exp_t        e;
    logic        ptrv, conf;
    int          base, w0, w1;
    logic [15:0] pv;
    nm   = m;
    ptrv = Ptr_Upd && (Ptr_Sel != 2'b00);
    base = 24 + 2 * int'(Ptr_Sel);
    w0 = -1; w1 = -1;
    if (Wr_Word) begin
      w0 = int'(mwa) & ~1;
      w1 = w0 + 1;
    end else if (Wr) begin
      w0 = int'(mwa);
    end
    conf = ptrv && (w0 == base || w0 == base + 1 || w1 == base || w1 == base + 1);
    if (ptrv && !conf) begin
      pv = {m[base + 1], m[base]};
      pv = Ptr_Dec ? pv - 16'd1 : pv + 16'd1;
      nm[base]     = pv[7:0];
      nm[base + 1] = pv[15:8];
    end
    if (w0 >= 0) nm[w0] = Data_In;
    if (w1 >= 0) nm[w1] = Data_In_Hi;
    e.rd = nm[Rd_Addr];
    e.rr = nm[Rr_Addr];
    e.x  = {nm[27], nm[26]};
    e.y  = {nm[29], nm[28]};
    e.z  = {nm[31], nm[30]};
    e.c  = conf;
    sbq.push_back(e);
    m   = nm;
    mwa = Rd_Addr;
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    check_val("rd_data", 32'(Rd_Data), 32'(e.rd));
    check_val("rr_data", 32'(Rr_Data), 32'(e.rr));
    check_val("x", 32'(X), 32'(e.x));
    check_val("y", 32'(Y), 32'(e.y));
    check_val("z", 32'(Z), 32'(e.z));
    check_val("conflict", 32'(Ptr_Conflict), 32'(e.c));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rd"}, 32'(Rd_Data), 32'h0);
    check_val({tag, "_rr"}, 32'(Rr_Data), 32'h0);
    check_val({tag, "_x"}, 32'(X), 32'h0);
    check_val({tag, "_y"}, 32'(Y), 32'h0);
    check_val({tag, "_z"}, 32'(Z), 32'h0);
    check_val({tag, "_conf"}, 32'(Ptr_Conflict), 32'h0);
  endtask

  initial begin
    Reset_n = 1'b0;
    idle(5'd0, 5'd0);
    model_clear();
    #12;
    check_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // byte write then read
    idle(5'd5, 5'd0); cyc();
    drive(1'b1, 1'b0, 5'd5, 5'd0, 8'hA5, 8'h00, 1'b0, 2'b00, 1'b0); cyc();
    idle(5'd5, 5'd0); cyc();
    check_val("byte_wr_rd", 32'(Rd_Data), 32'hA5);

    // bypass on port R
    idle(5'd7, 5'd0); cyc();
    drive(1'b1, 1'b0, 5'd7, 5'd0, 8'h11, 8'h00, 1'b0, 2'b00, 1'b0); cyc();
    drive(1'b1, 1'b0, 5'd0, 5'd7, 8'h3C, 8'h00, 1'b0, 2'b00, 1'b0); cyc();
    check_val("bypass_rr", 32'(Rr_Data), 32'h3C);

    // word write into Y using odd address
    idle(5'd29, 5'd0); cyc();
    drive(1'b0, 1'b1, 5'd29, 5'd28, 8'h34, 8'h12, 1'b0, 2'b00, 1'b0); cyc();
    check_val("word_y", 32'(Y), 32'h1234);
    check_val("word_lo_byp", 32'(Rr_Data), 32'h34);
    idle(5'd29, 5'd28); cyc();
    check_val("word_hi", 32'(Rd_Data), 32'h12);

    // Z wrap both directions
    idle(5'd31, 5'd0); cyc();
    drive(1'b0, 1'b1, 5'd0, 5'd0, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0); cyc();
    check_val("z_set", 32'(Z), 32'hFFFF);
    drive(1'b0, 1'b0, 5'd30, 5'd31, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0); cyc();
    check_val("z_inc_wrap", 32'(Z), 32'h0000);
    check_val("z_inc_byp", 32'(Rd_Data), 32'h00);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1); cyc();
    check_val("z_dec_wrap", 32'(Z), 32'hFFFF);

    // conflict: byte write into X low while X increments
    idle(5'd27, 5'd0); cyc();
    drive(1'b0, 1'b1, 5'd26, 5'd0, 8'h10, 8'h00, 1'b0, 2'b00, 1'b0); cyc();
    check_val("x_set", 32'(X), 32'h0010);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 8'h80, 8'h00, 1'b1, 2'b01, 1'b0); cyc();
    check_val("conf_x", 32'(X), 32'h0080);
    check_val("conf_flag", 32'(Ptr_Conflict), 32'h1);
    idle(5'd26, 5'd0); cyc();
    check_val("conf_clear", 32'(Ptr_Conflict), 32'h0);

    // carry across bytes on X, borrow on Y
    drive(1'b1, 1'b0, 5'd0, 5'd0, 8'hFF, 8'h00, 1'b0, 2'b00, 1'b0); cyc();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'h00, 1'b1, 2'b01, 1'b0); cyc();
    check_val("x_carry", 32'(X), 32'h0100);
    idle(5'd28, 5'd0); cyc();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0); cyc();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 8'h00, 1'b1, 2'b10, 1'b1); cyc();
    check_val("y_borrow", 32'(Y), 32'h11FF);

    // Ptr_Sel=00 is a no-op even alongside a pointer-pair write
    idle(5'd30, 5'd0); cyc();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 8'h42, 8'h00, 1'b1, 2'b00, 1'b0); cyc();
    check_val("noop_z", 32'(Z), 32'hFF42);
    check_val("noop_conf", 32'(Ptr_Conflict), 32'h0);

    // pointer update and unrelated write both take effect
    idle(5'd5, 5'd0); cyc();
    drive(1'b1, 1'b0, 5'd5, 5'd0, 8'h5A, 8'h00, 1'b1, 2'b11, 1'b0); cyc();
    check_val("indep_z", 32'(Z), 32'hFF43);
    check_val("indep_rd", 32'(Rd_Data), 32'h5A);

    // Wr and Wr_Word together: word behaviour wins
    idle(5'd9, 5'd0); cyc();
    drive(1'b1, 1'b1, 5'd8, 5'd9, 8'hAA, 8'hBB, 1'b0, 2'b00, 1'b0); cyc();
    check_val("both_lo", 32'(Rd_Data), 32'hAA);
    check_val("both_hi", 32'(Rr_Data), 32'hBB);

    // word write on Z high-byte address conflicts with Z update
    idle(5'd31, 5'd0); cyc();
    drive(1'b0, 1'b1, 5'd0, 5'd0, 8'h01, 8'h02, 1'b1, 2'b11, 1'b1); cyc();
    check_val("wconf_z", 32'(Z), 32'h0201);
    check_val("wconf_flag", 32'(Ptr_Conflict), 32'h1);

    // random traffic, biased toward pointer registers
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), ra, 5'($urandom_range(0, 31)),
            8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 0), 2'($urandom), 1'($urandom));
      cyc();
    end

    // reset between address and data cycle of a write
    idle(5'd3, 5'd3); cyc();
    drive(1'b1, 1'b0, 5'd3, 5'd3, 8'h77, 8'h00, 1'b1, 2'b01, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    model_clear();
    @(posedge Clk);
    #1;
    idle(5'd3, 5'd3);
    @(negedge Clk);
    Reset_n = 1'b1;
    idle(5'd3, 5'd3); cyc();
    idle(5'd3, 5'd3); cyc();
    check_val("post_reset_r3", 32'(Rd_Data), 32'h00);
    check_val("post_reset_x", 32'(X), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mf8_regfile_p.md
MF8_REGFILE_P -- requirements
Module: mf8_regfile_p

Interface
REQ-001 Parameter DW, default 8, data byte width in bits (DW >= 4).
REQ-002 Parameter AW, default 5, register address width; register count NREGS = 2**AW (AW >= 3).
REQ-003 Pointer pairs: X = regs {NREGS-5, NREGS-6}, Y = {NREGS-3, NREGS-4}, Z = {NREGS-1, NREGS-2}, listed {high, low}.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Wr  input  1  byte write enable, qualifies Data_In in the current cycle.
REQ-007 Wr_Word  input  1  pair write enable, qualifies {Data_In_Hi, Data_In} in the current cycle.
REQ-008 Rd_Addr  input  AW  read address for port D; also the write address for the following cycle.
REQ-009 Rr_Addr  input  AW  read address for port R.
REQ-010 Data_In  input  DW  write data, low byte.
REQ-011 Data_In_Hi  input  DW  write data, high byte (Wr_Word only).
REQ-012 Ptr_Upd  input  1  pointer increment/decrement request.
REQ-013 Ptr_Sel  input  2  pointer select: 01 X, 10 Y, 11 Z, 00 no-op.
REQ-014 Ptr_Dec  input  1  1 = decrement by 1, 0 = increment by 1.
REQ-015 Rd_Data  output  DW  port D read data.
REQ-016 Rr_Data  output  DW  port R read data.
REQ-017 X, Y, Z  output  2*DW each  current pointer pair values, {high, low}.
REQ-018 Ptr_Conflict  output  1  registered flag: the previous cycle's pointer update was discarded.

Function
REQ-019 Write address pipeline: Rd_Addr sampled at cycle N is the write address WA for Wr/Wr_Word in cycle N+1.
REQ-020 Wr in cycle N+1 stores Data_In into reg WA at the end of N+1.
REQ-021 Wr_Word stores Data_In into reg {WA[AW-1:1],0} and Data_In_Hi into reg {WA[AW-1:1],1}; WA[0] is ignored.
REQ-022 If Wr and Wr_Word are both high, Wr_Word behaviour applies and Wr is ignored.
REQ-023 Reads are synchronous: an address presented in cycle N produces data on Rd_Data/Rr_Data in cycle N+1, held until the next edge.
REQ-024 Bypass: if a register addressed by a read in cycle N is written in cycle N (byte, word or pointer update), cycle N+1 output shows the new value, not the old value.
REQ-025 Pointer update: Ptr_Upd with Ptr_Sel != 00 in cycle N replaces the selected pair P with (P ± 1) mod 2**(2*DW) at the end of N, carry/borrow propagating across both bytes.
REQ-026 Wrap: increment of all-ones yields 0; decrement of 0 yields all-ones.
REQ-027 Ptr_Upd with Ptr_Sel = 00 has no effect and does not set Ptr_Conflict.
REQ-028 Conflict: if Wr/Wr_Word in the same cycle targets any byte of the selected pair, the write completes as specified, the pointer update is discarded entirely, and Ptr_Conflict is 1 for the next cycle only.
REQ-029 Writes to pointer registers via Wr/Wr_Word update X/Y/Z outputs in the following cycle.
REQ-030 X/Y/Z outputs are direct views of the stored registers (no extra latency beyond the write edge).
REQ-031 Read ports D and R are independent; both may address the same register in the same cycle.

Reset
REQ-032 Reset_n low asynchronously clears all NREGS registers, the write address register, bypass state and Ptr_Conflict to 0; Rd_Data, Rr_Data, X, Y, Z, Ptr_Conflict read 0 while reset is asserted.
REQ-033 A write or pointer update in progress when Reset_n asserts is lost; the first valid write after reset requires Rd_Addr sampled on a clock edge with Reset_n high.

Verification
REQ-034 Byte write then read: Rd_Addr=5, next cycle Wr=1 Data_In=0xA5; Rd_Addr=5 one cycle later -> Rd_Data=0xA5 the cycle after.
REQ-035 Bypass: write 0x3C to reg 7 while Rr_Addr=7 in the same cycle -> Rr_Data=0x3C next cycle, not the old value.
REQ-036 Word write: WA=29, Wr_Word=1, Data_In=0x34, Data_In_Hi=0x12 -> reg 28=0x34, reg 29=0x12, Y=0x1234.
REQ-037 Pointer wrap: Z=0xFFFF, Ptr_Upd=1 Ptr_Sel=11 Ptr_Dec=0 -> Z=0x0000; then Ptr_Dec=1 -> Z=0xFFFF.
REQ-038 Conflict: X=0x0010, Ptr_Upd X increment with Wr to reg 26 Data_In=0x80 -> X=0x0080, Ptr_Conflict=1 for one cycle.
REQ-039 Reset mid-operation: assert Reset_n low between address and data cycle of a write -> all outputs 0, no register written after release.
